// File: rtl/aes_pkg.sv
// Shared AES constants, state/column types and GF(2^8) helpers.
package aes_pkg;

    localparam int NB   = 4;
    localparam int WORD = 8;

    typedef logic [NB*NB*WORD-1:0] aes_state_t;
    typedef logic [NB*WORD-1:0]    aes_col_t;

    function automatic logic [WORD-1:0] xtime(input logic [WORD-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Shift-and-add multiply; b is a constant at every call site, so this folds to an XOR tree.
    function automatic logic [WORD-1:0] gmul(input logic [WORD-1:0] a, input logic [WORD-1:0] b);
        logic [WORD-1:0] p;
        logic [WORD-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < WORD; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/mixcol_column.sv
// Combinational one-column (Inv)MixColumns transform with bypass.
// Inverse coefficients only exist when MIXCOLUMNS_INV_EN is defined.
module mixcol_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        inv_i,
    input  logic        bypass_i,
    output logic [31:0] col_o
);

    localparam logic [31:0] FWD_COEF = 32'h02030101;

    // Row r uses coefficient (j - r) mod 4 for input byte j: the circulant rotation.
    function automatic logic [7:0] mix_row(input logic [31:0] col, input logic [31:0] coef, input int row);
        logic [7:0] acc;
        acc = '0;
        for (int j = 0; j < 4; j++) begin
            acc = acc ^ gmul(col[31-8*j -: 8], coef[31-8*((j-row+4)%4) -: 8]);
        end
        return acc;
    endfunction

    aes_col_t fwd_col;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
        assign fwd_col[31-8*gi -: 8] = mix_row(col_i, FWD_COEF, gi);
    end

`ifdef MIXCOLUMNS_INV_EN
    localparam logic [31:0] INV_COEF = 32'h0e0b0d09;

    aes_col_t inv_col;

    for (genvar gi = 0; gi < 4; gi++) begin : g_inv
        assign inv_col[31-8*gi -: 8] = mix_row(col_i, INV_COEF, gi);
    end

    assign col_o = bypass_i ? col_i : (inv_i ? inv_col : fwd_col);
`else
    logic unused_inv;
    assign unused_inv = inv_i;
    assign col_o = bypass_i ? col_i : fwd_col;
`endif

endmodule

// File: rtl/mixcolumns_iter.sv
// Iterative MixColumns: one column per clock, 6-cycle block period, final-round bypass.
// Define MIXCOLUMNS_INV_EN to add the i_inv port and InvMixColumns support.
module mixcolumns_iter #(
    parameter int NB   = 4,
    parameter int WORD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic                   i_last,
    input  logic [NB*NB*WORD-1:0]  i_block,
`ifdef MIXCOLUMNS_INV_EN
    input  logic                   i_inv,
`endif
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [NB*NB*WORD-1:0]  o_block
);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_e;

    state_e                 state_q;
    logic [1:0]             col_q;
    logic [3:0][31:0]       shadow_q;
    logic [3:0][31:0]       result_q;
    logic [3:0][31:0]       result_d;
    logic                   last_q;
    logic                   inv_sel;
    logic                   o_valid_q;
    aes_pkg::aes_state_t    o_block_q;
    aes_pkg::aes_col_t      col_out;
    logic [1:0]             slot;

    // Column 0 lives in the top 32 bits, i.e. packed index 3.
    assign slot = 2'd3 - col_q;

`ifdef MIXCOLUMNS_INV_EN
    logic inv_q;
    assign inv_sel = inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    mixcol_column u_col (
        .col_i    (shadow_q[slot]),
        .inv_i    (inv_sel),
        .bypass_i (last_q),
        .col_o    (col_out)
    );

    always_comb begin
        result_d       = result_q;
        result_d[slot] = col_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_q     <= 2'd0;
            shadow_q  <= '0;
            result_q  <= '0;
            last_q    <= 1'b0;
            o_valid_q <= 1'b0;
            o_block_q <= '0;
`ifdef MIXCOLUMNS_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            o_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        shadow_q <= i_block;
                        last_q   <= i_last;
`ifdef MIXCOLUMNS_INV_EN
                        inv_q    <= i_inv;
`endif
                        col_q    <= 2'd0;
                        state_q  <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    result_q <= result_d;
                    col_q    <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        o_block_q <= result_d;
                        o_valid_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_valid = o_valid_q;
    assign o_block = o_block_q;

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Scoreboard bench for mixcolumns_iter: expected blocks queued at accept, popped on o_valid.
module tb_mixcolumns_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_last;
    logic [127:0] i_block;
`ifdef MIXCOLUMNS_INV_EN
    logic         i_inv;
`endif
    logic         o_ready;
    logic         o_valid;
    logic [127:0] o_block;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] exp_q[$];

    localparam logic [127:0] R1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] R1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] C1_IN  = {4{32'hdb135345}};
    localparam logic [127:0] C1_OUT = {4{32'h8e4da1bc}};
    localparam logic [127:0] C2_IN  = {4{32'hf20a225c}};
    localparam logic [127:0] C2_OUT = {4{32'h9fdc589d}};
    localparam logic [127:0] C3_IN  = {32'hc6c6c6c6, 32'h01010101, 32'hdb135345, 32'hf20a225c};
    localparam logic [127:0] C3_OUT = {32'hc6c6c6c6, 32'h01010101, 32'h8e4da1bc, 32'h9fdc589d};
    localparam logic [127:0] C4_IN  = {32'h01010101, 32'hc6c6c6c6, 32'hf20a225c, 32'hdb135345};
    localparam logic [127:0] C4_OUT = {32'h01010101, 32'hc6c6c6c6, 32'h9fdc589d, 32'h8e4da1bc};

    always #5 clk = ~clk;

    mixcolumns_iter #(.NB(4), .WORD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_block (i_block),
`ifdef MIXCOLUMNS_INV_EN
        .i_inv   (i_inv),
`endif
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_block (o_block)
    );

    // Reference: carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gm_model(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mc_model(input logic [127:0] b, input logic inv);
        logic [31:0]  rows [4];
        logic [127:0] r;
        logic [7:0]   acc;
        rows[0] = inv ? 32'h0e0b0d09 : 32'h02030101;
        rows[1] = inv ? 32'h090e0b0d : 32'h01020301;
        rows[2] = inv ? 32'h0d090e0b : 32'h01010203;
        rows[3] = inv ? 32'h0b0d090e : 32'h03010102;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gm_model(b[127-32*c-8*j -: 8], rows[rr][31-8*j -: 8]);
                r[127-32*c-8*rr -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic run_block(input logic [127:0] blk, input logic last, input logic inv,
                             input logic [127:0] exp, input string name);
        int           pulses;
        logic [127:0] got_exp;
        pulses  = 0;
        got_exp = '0;
        exp_q.push_back(exp);
        @(negedge clk);
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, o_ready);
        end
        i_valid = 1'b1;
        i_block = blk;
        i_last  = last;
`ifdef MIXCOLUMNS_INV_EN
        i_inv   = inv;
`else
        if (inv) $display("[TB] %s: inverse requested but not built", name);
`endif
        @(posedge clk);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                i_valid = 1'b0;
                i_block = ~blk;
                i_last  = ~last;
            end
            tests_run++;
            if (o_ready !== (k >= 5)) begin
                tests_failed++;
                $display("FAIL %s ready@N+%0d: got %b want %b", name, k, o_ready, (k >= 5));
            end
            tests_run++;
            if (o_valid !== (k == 4)) begin
                tests_failed++;
                $display("FAIL %s valid@N+%0d: got %b want %b", name, k, o_valid, (k == 4));
            end
            if (o_valid === 1'b1) begin
                pulses++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s unexpected_output: got %h want none", name, o_block);
                end else begin
                    got_exp = exp_q.pop_front();
                    if (o_block !== got_exp) begin
                        tests_failed++;
                        $display("FAIL %s data: got %h want %h", name, o_block, got_exp);
                    end
                end
            end
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL %s pulse_count: got %0d want 1", name, pulses);
        end
        tests_run++;
        if (o_block !== exp) begin
            tests_failed++;
            $display("FAIL %s hold_after_pulse: got %h want %h", name, o_block, exp);
        end
        exp_q.delete();
        $display("[TB] %s: in=%h last=%b inv=%b out=%h", name, blk, last, inv, o_block);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_block = '0;
`ifdef MIXCOLUMNS_INV_EN
        i_inv   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_block !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got valid=%b ready=%b block=%h want 0/1/0", o_valid, o_ready, o_block);
        end
        rst = 1'b0;
        $display("[TB] reset: valid=%b ready=%b block=%h", o_valid, o_ready, o_block);
    endtask

    task automatic test_fips_round1();
        run_block(R1_IN, 1'b0, 1'b0, R1_OUT, "fips_round1");
    endtask

    task automatic test_column_vectors();
        run_block(C1_IN, 1'b0, 1'b0, C1_OUT, "col_db135345");
        run_block(C2_IN, 1'b0, 1'b0, C2_OUT, "col_f20a225c");
        run_block(C3_IN, 1'b0, 1'b0, C3_OUT, "col_mix_a");
        run_block(C4_IN, 1'b0, 1'b0, C4_OUT, "col_mix_b");
    endtask

    task automatic test_bypass();
        run_block(R1_IN, 1'b1, 1'b0, R1_IN, "bypass_round1");
        run_block(C1_IN, 1'b1, 1'b0, C1_IN, "bypass_col");
    endtask

    task automatic test_random();
        logic [127:0] b;
        for (int n = 0; n < 3; n++) begin
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_block(b, 1'b0, 1'b0, mc_model(b, 1'b0), "random_fwd");
        end
    endtask

    task automatic test_back_to_back();
        int           pulses;
        logic         exp_ready;
        logic         exp_valid;
        logic [127:0] got_exp;
        pulses = 0;
        exp_q.push_back(R1_OUT);
        exp_q.push_back(C3_OUT);
        @(negedge clk);
        i_valid = 1'b1;
        i_block = R1_IN;
        i_last  = 1'b0;
`ifdef MIXCOLUMNS_INV_EN
        i_inv   = 1'b0;
`endif
        @(posedge clk);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) i_block = C3_IN;
            exp_ready = (k == 5) || (k >= 11);
            exp_valid = (k == 4) || (k == 10);
            tests_run++;
            if (o_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL b2b ready@N+%0d: got %b want %b", k, o_ready, exp_ready);
            end
            tests_run++;
            if (o_valid !== exp_valid) begin
                tests_failed++;
                $display("FAIL b2b valid@N+%0d: got %b want %b", k, o_valid, exp_valid);
            end
            if (o_valid === 1'b1) begin
                pulses++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b unexpected_output: got %h want none", o_block);
                end else begin
                    got_exp = exp_q.pop_front();
                    if (o_block !== got_exp) begin
                        tests_failed++;
                        $display("FAIL b2b data#%0d: got %h want %h", pulses, o_block, got_exp);
                    end
                end
            end
            if (k == 6) i_valid = 1'b0;
        end
        tests_run++;
        if (pulses != 2) begin
            tests_failed++;
            $display("FAIL b2b pulse_count: got %0d want 2", pulses);
        end
        exp_q.delete();
        $display("[TB] back_to_back: pulses=%0d last_out=%h", pulses, o_block);
    endtask

    task automatic test_reset_midblock();
        int high_seen;
        high_seen = 0;
        @(negedge clk);
        i_valid = 1'b1;
        i_block = C2_IN;
        i_last  = 1'b0;
`ifdef MIXCOLUMNS_INV_EN
        i_inv   = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_block !== '0) begin
            tests_failed++;
            $display("FAIL midreset_state: got ready=%b valid=%b block=%h want 1/0/0", o_ready, o_valid, o_block);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_valid === 1'b1) high_seen++;
        end
        tests_run++;
        if (high_seen != 0 || o_block !== '0) begin
            tests_failed++;
            $display("FAIL midreset_no_valid: got pulses=%0d block=%h want 0/0", high_seen, o_block);
        end
        $display("[TB] reset_midblock: pulses=%0d block=%h", high_seen, o_block);
        run_block(R1_IN, 1'b0, 1'b0, R1_OUT, "after_midreset");
    endtask

`ifdef MIXCOLUMNS_INV_EN
    task automatic test_inverse();
        logic [127:0] b;
        logic [127:0] fwd;
        run_block(R1_OUT, 1'b0, 1'b1, R1_IN, "inv_round1");
        for (int n = 0; n < 3; n++) begin
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_block(b, 1'b0, 1'b0, mc_model(b, 1'b0), "trip_fwd");
            fwd = o_block;
            run_block(fwd, 1'b0, 1'b1, b, "trip_inv");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips_round1();
        test_column_vectors();
        test_bypass();
        test_back_to_back();
        test_random();
        test_reset_midblock();
`ifdef MIXCOLUMNS_INV_EN
        test_inverse();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mixcolumns_iter.md
# mixcolumns_iter

Iterative AES MixColumns stage that sits directly downstream of `shiftrows` in the round datapath. It consumes the 128-bit column-major state that `shiftrows` produces and transforms one 32-bit column per clock. It returns the full 128-bit result with a one-cycle `o_valid` pulse. A per-block bypass passes the state through unchanged for the final AES round, and an optional compile-time inverse mode supports decryption.

## Interface
- `NB`, default 4: state columns/rows; only 4 is supported.
- `WORD`, default 8: bits per byte; only 8 is supported.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `i_valid` input 1: input block present; accepted only when `o_ready`=1.
- `i_last` input 1: final round; block bypasses MixColumns. Sampled with `i_valid`.
- `i_block` input NB\*NB\*WORD: state input. Column c occupies [127-32c -: 32]; row 0 is the MSB byte of each column.
- `i_inv` input 1: select InvMixColumns. Present only with `MIXCOLUMNS_INV_EN`; sampled with `i_valid`.
- `o_ready` output 1: block idle and able to accept input (state==IDLE).
- `o_valid` output 1: one-cycle pulse; `o_block` holds a valid result.
- `o_block` output NB\*NB\*WORD: result, same layout as `i_block`.

## Operation
- FSM has three states: IDLE, COMPUTE, DONE. Reset enters IDLE.
- IDLE:
  - If `i_valid`=1: latch `i_block`, `i_last` and `i_inv` into shadow registers, clear column counter `col`, and go to COMPUTE.
  - Else stay in IDLE.
- COMPUTE:
  - Each cycle, transform shadow column `col` and write it into result column `col`; increment `col`.
  - When `col`==3 is written, load `o_block` from the result and go to DONE.
  - `col` is 2 bits. Its wrap from 3 to 0 is not used; the counter is cleared on accept.
- DONE: `o_valid`=1 for this cycle only, then go to IDLE.
- Column transform, forward mode (a0..a3 = rows 0..3):
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
- Inverse mode uses coefficients 0e/0b/0d/09 in the same rotation.
- GF(2^8) arithmetic:
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 0).
  - All products are built from xtime and XOR. Results are 8 bits wide; there is no carry.
- Bypass: when latched `i_last`=1, each column is copied unchanged. Latency is the same as a normal block.
- `i_valid` while `o_ready`=0 is ignored; the block is not queued. Upstream must hold `i_valid` until `o_ready`=1.
- `i_block` may change any time after the accept edge.
- Reset mid-operation:
  - FSM returns to IDLE at once; `o_valid` and `o_block` clear.
  - No partial result is ever flagged valid.

## Timing
- Reset values: `o_valid`=0, `o_block`=0, `o_ready`=1.
- Accept at edge N (IDLE, `i_valid`=1):
  - Columns 0..3 are written at edges N+1..N+4.
  - `o_block` is loaded at edge N+4; `o_valid` goes high after edge N+4 and low after edge N+5.
- `o_ready`:
  - Low from edge N through edge N+5.
  - The next block can be accepted at edge N+6.
  - Throughput is 1 block per 6 cycles.
- `o_block` holds its value after the `o_valid` pulse until the next load or reset.
- `o_ready` is combinational from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- `MIXCOLUMNS_INV_EN` defined:
  - The `i_inv` port exists.
  - When latched `i_inv`=1, the block computes InvMixColumns.
- Undefined:
  - The port is absent and the block is forward-only.
  - Inverse multiplier logic is not synthesized.

## Structure
- Shared package `aes_pkg` holds:
  - `NB` and `WORD` constants;
  - a 128-bit state typedef and a 32-bit column typedef;
  - `xtime` and `gmul` functions.
- The FSM state enum stays local to the module.
- Sub-module `mixcol_column`: a combinational one-column transform.
  - Inputs: 32-bit column, `inv`, `bypass`.
  - Output: 32-bit column.
  - One instance, muxed by `col`.

## Test plan
- Forward, FIPS-197 round 1:
  - Input: d4bf5d30 e0b452ae b84111f1 1e2798e5.
  - Expect: 046681e5 e0cb199a 48f8d37a 2806264c.
  - Accept at edge N; `o_valid` pulses exactly once after edge N+4.
- Column vectors:
  - db135345 -> 8e4da1bc in every column slot.
  - f20a225c -> 9fdc589d.
  - c6c6c6c6 and 01010101 are unchanged.
- Bypass: `i_last`=1 with the round-1 input -> output equals input, with the same latency.
- Back-pressure:
  - Assert `i_valid` continuously with two different blocks.
  - Second block accepted at edge N+6 only; it is never dropped or corrupted.
  - `o_ready` low for edges N..N+5.
- Reset at cycle N+2 mid-block:
  - `o_valid` never asserts; `o_block`=0.
  - `o_ready`=1 immediately.
  - The next block computes correctly.
- With `MIXCOLUMNS_INV_EN`:
  - `i_inv`=1 on 046681e5 e0cb199a 48f8d37a 2806264c -> d4bf5d30 e0b452ae b84111f1 1e2798e5.
  - Forward-then-inverse round trip on random blocks returns the original.
